seg7_digit_scanner: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a packed hex value and walks one digit at a time at a programmable refresh rate. For each digit it presents the 4-bit nibble to the downstream `hex_to_7seg` decoder and asserts the matching anode. New values are taken in through a valid/ready handshake and applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_digit_scanner_if.sv | 13 +
 rtl/seg7_tick_gen.sv | 22 ++
 rtl/seg7_digit_scanner.sv | 74 +++++++
 tb/tb_seg7_digit_scanner.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types, defaults and anode encoding for the seven-segment digit scanner.
package seg7_pkg;
    localparam int SEG7_DEFAULT_DIGITS = 4;
    localparam int SEG7_DEFAULT_DIV    = 50000;
    localparam int SEG7_MAX_DIGITS     = 8;

    typedef logic [3:0] nibble_t;

    // One-hot anode pattern sized for the widest display; callers truncate.
    function automatic logic [SEG7_MAX_DIGITS-1:0] an_encode(input logic [2:0] idx,
                                                              input logic active_low);
        logic [SEG7_MAX_DIGITS-1:0] oh;
        oh = SEG7_MAX_DIGITS'(1) << idx;
        return active_low ? ~oh : oh;
    endfunction
endpackage

// File: rtl/seg7_digit_scanner_if.sv
// Value-load handshake between a producer and the digit scanner.
interface seg7_digit_scanner_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = SEG7_DEFAULT_DIGITS
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] value_in;

    modport master (output load_valid, output value_in, input load_ready);
    modport slave  (input load_valid, input value_in, output load_ready);
endinterface

// File: rtl/seg7_tick_gen.sv
// Refresh prescaler: one-cycle tick every REFRESH_DIV clocks.
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = SEG7_DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with frame-aligned value
// updates and optional leading-zero blanking.
module seg7_digit_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = SEG7_DEFAULT_DIGITS,
    parameter int REFRESH_DIV   = SEG7_DEFAULT_DIV,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    seg7_digit_scanner_if.slave           bus,
    input  logic                          blank_lz,
    output nibble_t                       hex_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int W  = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic          tick;
    logic          last_digit;
    logic          wrap;
    logic [W-1:0]  disp;
    logic [W-1:0]  pend;
    logic          pend_v;
    logic [W-1:0]  upper;
    nibble_t       cur_nib;
    logic          blank;

    seg7_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign last_digit     = (digit_idx == IW'(NUM_DIGITS - 1));
    assign wrap           = tick && last_digit;
    assign bus.load_ready = !pend_v;

    // A digit is blank when it and every digit to its left are zero.
    always_comb begin
        upper   = disp >> {digit_idx, 2'b00};
        cur_nib = disp[{digit_idx, 2'b00} +: 4];
        blank   = blank_lz && (digit_idx != '0) && (upper == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_idx <= '0;
            disp      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            hex_out   <= '0;
            an_out    <= AN_OFF;
        end else begin
            hex_out <= cur_nib;
            an_out  <= blank ? AN_OFF
                             : NUM_DIGITS'(an_encode(3'(digit_idx), AN_ACTIVE_LOW));
            if (tick)
                digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
            // Apply looks at pend_v before this cycle's transfer can set it.
            if (wrap && pend_v) begin
                disp   <= pend;
                pend_v <= 1'b0;
            end
            if (bus.load_valid && bus.load_ready) begin
                pend   <= bus.value_in;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Scoreboard bench: driver pushes expected post-edge outputs from a
// cycle-count reference model; monitor pops and compares after each edge.
module tb_seg7_digit_scanner;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int FR  = N * DIV;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blank_lz = 1'b0;
    logic [3:0]   hex_out;
    logic [N-1:0] an_out;
    logic [1:0]   digit_idx;

    always #5 clk = ~clk;

    seg7_digit_scanner_if #(.NUM_DIGITS(N)) bus ();

    seg7_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .blank_lz (blank_lz),
        .hex_out  (hex_out),
        .an_out   (an_out),
        .digit_idx(digit_idx)
    );

    typedef struct {
        logic [3:0] hex;
        logic [3:0] an;
        logic       ready;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: scan position derived purely from cycles since reset.
    int          cyc = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 1'b0;
    bit          last_xfer = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit lv, input logic [15:0] v, input bit blz);
        exp_t e;
        int   idx;
        bit   blank, wrap, xfer;
        @(negedge clk);
        rst_n          = r;
        bus.load_valid = lv;
        bus.value_in   = v;
        blank_lz       = blz;
        xfer           = 1'b0;
        if (!r) begin
            cyc = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
            e.hex = 4'h0;
            e.an  = 4'hF;
        end else begin
            idx   = (cyc / DIV) % N;
            blank = blz && idx > 0 && ((m_disp >> (4 * idx)) == 16'h0);
            e.hex = m_disp[4*idx +: 4];
            e.an  = blank ? 4'hF : ~(4'b0001 << idx);
            wrap  = (cyc % FR) == FR - 1;
            xfer  = lv && !m_pv;
            if (wrap && m_pv) begin m_disp = m_pend; m_pv = 1'b0; end
            if (xfer) begin m_pend = v; m_pv = 1'b1; end
            cyc++;
        end
        e.ready   = !m_pv;
        e.idx     = 2'((cyc / DIV) % N);
        last_xfer = xfer;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input bit blz);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, blz);
    endtask

    // Offer v and hold it until accepted (bounded).
    task automatic load(input logic [15:0] v, input bit blz);
        for (int i = 0; i < 4 * FR; i++) begin
            step(1'b1, 1'b1, v, blz);
            if (last_xfer) return;
        end
        check("load_accept_timeout", 16'h0, 16'h1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("hex_out",    16'(hex_out),        16'(e.hex));
                check("an_out",     16'(an_out),         16'(e.an));
                check("load_ready", 16'(bus.load_ready), 16'(e.ready));
                check("digit_idx",  16'(digit_idx),      16'(e.idx));
                if (an_out !== 4'hF && $countones(~an_out) != 1)
                    check("an_onehot", 16'(an_out), 16'hF);
            end
        end
    end

    initial begin : driver
        bit          lv;
        logic [15:0] v;
        bit          blz;
        bit          r;
        bus.load_valid = 1'b0;
        bus.value_in   = '0;

        // Reset held three cycles, then free-run
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        idle(9, 1'b0);

        // Load and scan
        load(16'hA3C5, 1'b0);
        idle(3 * FR, 1'b0);

        // Back-pressure: second value held until the first is applied
        load(16'h1234, 1'b0);
        load(16'hBEEF, 1'b0);
        idle(3 * FR, 1'b0);

        // Transfer exactly on the frame-wrap cycle
        for (int i = 0; i < FR && (cyc % FR) != FR - 1; i++) idle(1, 1'b0);
        load(16'h00F0, 1'b0);
        idle(3 * FR, 1'b0);

        // Leading-zero blanking on and off
        load(16'h0007, 1'b1);
        idle(2 * FR, 1'b1);
        idle(2 * FR, 1'b0);

        // Reset mid-frame with a pending value
        for (int i = 0; i < FR && (cyc % FR) != 0; i++) idle(1, 1'b0);
        load(16'h9876, 1'b0);
        for (int i = 0; i < FR && ((cyc / DIV) % N) != 2; i++) idle(1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        idle(2 * FR, 1'b0);

        // Randomized traffic honouring the hold-until-ready rule
        lv = 1'b0; v = '0; blz = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!lv && $urandom_range(0, 3) == 0) begin
                lv = 1'b1;
                v  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) blz = ~blz;
            r = ($urandom_range(0, 99) != 0);
            step(r, lv, v, blz);
            if (last_xfer || !r) lv = 1'b0;
        end
        idle(2, 1'b0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
